// File: rtl/stack_param_sync.sv
// Parametrised command-driven LIFO operand stack.
// The stack is a circular buffer addressed by 'top', which points at the next free slot.
// COUNT tracks occupancy independently, so the same storage can do two things:
// - WRAP=1 overwrites the oldest entry when full and reads stale words when empty.
// - WRAP=0 rejects over/underflow and out-of-range GETs with a one-cycle ERR pulse.
// Outputs and handshake:
// - DATA_OUT/OUT_VALID/ERR are registered.
// - OUT_VALID and ERR are single-cycle pulses, and they are never asserted together.
// - DATA_OUT is zero whenever OUT_VALID is low.
// - There is no backpressure: one command is accepted on every rising edge.
module stack_param_sync #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 5,
  parameter  int IDX_W = 3,
  parameter  int WRAP  = 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             notCLK,
  input  logic             RESET,
  input  logic [2:0]       COMMAND,
  input  logic [IDX_W-1:0] INDEX,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             OUT_VALID,
  output logic             ERR,
  output logic [CNT_W-1:0] COUNT,
  output logic             FULL,
  output logic             EMPTY
);

  localparam int          PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] D     = 32'(DEPTH);
  localparam bit          SAT   = (WRAP == 0);

  typedef enum logic [2:0] {
    CMD_NOP   = 3'b000,
    CMD_PUSH  = 3'b001,
    CMD_POP   = 3'b010,
    CMD_GET   = 3'b011,
    CMD_CLEAR = 3'b100,
    CMD_DUP   = 3'b101
  } cmd_e;

  cmd_e             cmd;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] top;
  logic [PTR_W-1:0] prev_addr;
  logic [PTR_W-1:0] next_addr;
  logic [PTR_W-1:0] get_addr;
  logic [31:0]      top_ext;
  logic [31:0]      idx_red;

  assign cmd = cmd_e'(COMMAND);

  assign FULL  = (COUNT == CNT_W'(DEPTH));
  assign EMPTY = (COUNT == '0);

  // Pointer arithmetic.
  // Offsets of DEPTH are added before each modulo, so nothing underflows for any DEPTH.
  // Reserved command codes fall into the default branch of the case below, so they act as NOP.
  assign top_ext   = 32'(top);
  assign idx_red   = 32'(INDEX) % D;
  assign prev_addr = PTR_W'((top_ext + D - 32'd1) % D);
  assign next_addr = PTR_W'((top_ext + 32'd1) % D);
  assign get_addr  = PTR_W'((top_ext + 32'd2 * D - 32'd1 - idx_red) % D);

  // Command execution: reset/CLEAR wipe everything, otherwise one command per edge.
  always_ff @(posedge notCLK) begin
    OUT_VALID <= 1'b0;
    ERR       <= 1'b0;
    DATA_OUT  <= '0;
    if (RESET || cmd == CMD_CLEAR) begin
      top   <= '0;
      COUNT <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (cmd)
        CMD_PUSH, CMD_DUP: begin
          if ((SAT && FULL) || (SAT && EMPTY && cmd == CMD_DUP)) begin
            ERR <= 1'b1;
          end else begin
            mem[top] <= (cmd == CMD_DUP) ? mem[prev_addr] : DATA_IN;
            top      <= next_addr;
            if (!FULL) COUNT <= COUNT + 1'b1;
          end
        end
        CMD_POP: begin
          if (SAT && EMPTY) begin
            ERR <= 1'b1;
          end else begin
            top       <= prev_addr;
            DATA_OUT  <= mem[prev_addr];
            OUT_VALID <= 1'b1;
            if (!EMPTY) COUNT <= COUNT - 1'b1;
          end
        end
        CMD_GET: begin
          if (SAT && (32'(INDEX) >= 32'(COUNT))) begin
            ERR <= 1'b1;
          end else begin
            DATA_OUT  <= mem[get_addr];
            OUT_VALID <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_param_sync.sv
// Bench for stack_param_sync.
// - One instance is built with WRAP=1 and a second with WRAP=0.
// - Directed commands push their expected {ERR, OUT_VALID, DATA_OUT} into a per-instance queue.
// - Monitors pop and compare on every output pulse.
// - Occupancy and flags are checked directly after each relevant command.
module tb_stack_param_sync;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, GET = 3'd3,
                         CLEAR = 3'd4, DUP = 3'd5, RSVD = 3'd6;

  logic notCLK = 1'b0;
  always #5 notCLK = ~notCLK;

  int tests = 0;
  int fails = 0;

  logic       rst_w, rst_s;
  logic [2:0] cmd_w, cmd_s, idx_w, idx_s;
  logic [3:0] din_w, din_s, dout_w, dout_s;
  logic       ov_w, ov_s, err_w, err_s, full_w, full_s, empty_w, empty_s;
  logic [2:0] cnt_w, cnt_s;

  logic [5:0] exp_w[$];
  logic [5:0] exp_s[$];

  stack_param_sync #(.WIDTH(4), .DEPTH(5), .IDX_W(3), .WRAP(1)) u_wrap (
    .notCLK(notCLK), .RESET(rst_w), .COMMAND(cmd_w), .INDEX(idx_w), .DATA_IN(din_w),
    .DATA_OUT(dout_w), .OUT_VALID(ov_w), .ERR(err_w), .COUNT(cnt_w), .FULL(full_w), .EMPTY(empty_w)
  );

  stack_param_sync #(.WIDTH(4), .DEPTH(5), .IDX_W(3), .WRAP(0)) u_sat (
    .notCLK(notCLK), .RESET(rst_s), .COMMAND(cmd_s), .INDEX(idx_s), .DATA_IN(din_s),
    .DATA_OUT(dout_s), .OUT_VALID(ov_s), .ERR(err_s), .COUNT(cnt_s), .FULL(full_s), .EMPTY(empty_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst_w = 1'b0; cmd_w = NOP; idx_w = '0; din_w = '0;
    rst_s = 1'b0; cmd_s = NOP; idx_s = '0; din_s = '0;
  endtask

  // kind: 0 = no output pulse expected, 1 = OUT_VALID with data ed, 2 = ERR.
  task automatic op(input bit s, input bit rst, input logic [2:0] c, input logic [2:0] idx,
                    input logic [3:0] d, input int kind, input logic [3:0] ed);
    idle();
    if (!s) begin
      rst_w = rst; cmd_w = c; idx_w = idx; din_w = d;
      if (kind == 1) exp_w.push_back({2'b01, ed});
      else if (kind == 2) exp_w.push_back(6'b100000);
    end else begin
      rst_s = rst; cmd_s = c; idx_s = idx; din_s = d;
      if (kind == 1) exp_s.push_back({2'b01, ed});
      else if (kind == 2) exp_s.push_back(6'b100000);
    end
    @(posedge notCLK);
    #1;
    idle();
  endtask

  task automatic status(input bit s, input string name, input int cnt, input bit fl, input bit em);
    if (!s) check(name, {27'd0, cnt_w, full_w, empty_w}, {27'd0, 3'(cnt), fl, em});
    else    check(name, {27'd0, cnt_s, full_s, empty_s}, {27'd0, 3'(cnt), fl, em});
  endtask

  // Monitor for the WRAP=1 instance.
  always @(negedge notCLK) begin
    if (ov_w === 1'b1 || err_w === 1'b1) begin
      if (exp_w.size() == 0) begin
        tests++; fails++;
        $display("FAIL wrap_unexpected_pulse: got err=%0b valid=%0b data=0x%0h, expected none",
                 err_w, ov_w, dout_w);
      end else begin
        check("wrap_out", 32'({err_w, ov_w, dout_w}), 32'(exp_w.pop_front()));
      end
    end
  end

  // Monitor for the WRAP=0 instance.
  always @(negedge notCLK) begin
    if (ov_s === 1'b1 || err_s === 1'b1) begin
      if (exp_s.size() == 0) begin
        tests++; fails++;
        $display("FAIL sat_unexpected_pulse: got err=%0b valid=%0b data=0x%0h, expected none",
                 err_s, ov_s, dout_s);
      end else begin
        check("sat_out", 32'({err_s, ov_s, dout_s}), 32'(exp_s.pop_front()));
      end
    end
  end

  initial begin
    idle();
    rst_w = 1'b1; rst_s = 1'b1;
    repeat (2) @(posedge notCLK);
    #1;
    idle();
    status(0, "wrap_reset_status", 0, 0, 1);
    status(1, "sat_reset_status", 0, 0, 1);
    check("wrap_reset_dout", 32'({ov_w, err_w, dout_w}), 32'd0);
    check("sat_reset_dout", 32'({ov_s, err_s, dout_s}), 32'd0);

    // WRAP=1: push 1,2,3 then pop.
    op(0, 0, PUSH, 0, 4'd1, 0, 0);
    op(0, 0, PUSH, 0, 4'd2, 0, 0);
    op(0, 0, PUSH, 0, 4'd3, 0, 0);
    op(0, 0, POP, 0, 0, 1, 4'd3);
    status(0, "wrap_pop_status", 2, 0, 0);

    // Refill to 1,2,3 and read by depth, including an INDEX reduced mod DEPTH.
    op(0, 0, PUSH, 0, 4'd3, 0, 0);
    op(0, 0, GET, 3'd0, 0, 1, 4'd3);
    op(0, 0, GET, 3'd1, 0, 1, 4'd2);
    op(0, 0, GET, 3'd2, 0, 1, 4'd1);
    status(0, "wrap_get_status", 3, 0, 0);
    op(0, 0, GET, 3'd7, 0, 1, 4'd1);

    // WRAP=1 overflow overwrites, underflow returns the stale word.
    op(0, 1, NOP, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) op(0, 0, PUSH, 0, 4'(i), 0, 0);
    status(0, "wrap_full_status", 5, 1, 0);
    op(0, 0, POP, 0, 0, 1, 4'd6);
    op(0, 0, POP, 0, 0, 1, 4'd5);
    op(0, 0, POP, 0, 0, 1, 4'd4);
    op(0, 0, POP, 0, 0, 1, 4'd3);
    op(0, 0, POP, 0, 0, 1, 4'd2);
    status(0, "wrap_drained_status", 0, 0, 1);
    op(0, 0, POP, 0, 0, 1, 4'd6);
    status(0, "wrap_stale_pop_status", 0, 0, 1);

    // RESET overrides a PUSH on the same edge.
    op(0, 0, PUSH, 0, 4'd5, 0, 0);
    op(0, 1, PUSH, 0, 4'hA, 0, 0);
    status(0, "wrap_reset_override_status", 0, 0, 1);
    check("wrap_reset_override_dout", 32'(dout_w), 32'd0);
    op(0, 0, GET, 3'd0, 0, 1, 4'd0);

    // WRAP=0: overflow rejected.
    for (int i = 1; i <= 5; i++) op(1, 0, PUSH, 0, 4'(i), 0, 0);
    op(1, 0, PUSH, 0, 4'd6, 2, 0);
    status(1, "sat_full_status", 5, 1, 0);
    op(1, 0, POP, 0, 0, 1, 4'd5);
    op(1, 0, POP, 0, 0, 1, 4'd4);
    op(1, 0, POP, 0, 0, 1, 4'd3);
    op(1, 0, POP, 0, 0, 1, 4'd2);
    op(1, 0, POP, 0, 0, 1, 4'd1);
    status(1, "sat_drained_status", 0, 0, 1);
    op(1, 0, POP, 0, 0, 2, 0);
    op(1, 0, GET, 3'd0, 0, 2, 0);
    op(1, 0, DUP, 0, 0, 2, 0);
    status(1, "sat_underflow_status", 0, 0, 1);

    // WRAP=0: DUP, GET range boundary, reserved code, CLEAR.
    op(1, 0, PUSH, 0, 4'd9, 0, 0);
    op(1, 0, DUP, 0, 0, 0, 0);
    op(1, 0, DUP, 0, 0, 0, 0);
    status(1, "sat_dup_status", 3, 0, 0);
    op(1, 0, GET, 3'd2, 0, 1, 4'd9);
    op(1, 0, GET, 3'd3, 0, 2, 0);
    op(1, 0, RSVD, 0, 4'd7, 0, 0);
    status(1, "sat_reserved_status", 3, 0, 0);
    op(1, 0, CLEAR, 0, 0, 0, 0);
    status(1, "sat_clear_status", 0, 0, 1);
    op(1, 0, GET, 3'd0, 0, 2, 0);

    repeat (3) @(posedge notCLK);
    #1;
    check("wrap_queue_drained", 32'(exp_w.size()), 32'd0);
    check("sat_queue_drained", 32'(exp_s.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
